cvbs_syncgen: RTL
=================

Name: cvbs_syncgen

Overview:
- Composite sync transmitter: generates PAL-style line/field timing and a 6-bit sync-level CVBS stream at 24 MHz.
- It is the counterpart of syncdetect. cvbs_syncgen produces the waveform that syncdetect decodes back into hsync, vsync and porch.
- Used as the in-fabric timing master when no external video source exists, and as the loopback stimulus source for syncdetect.
- Also drives the video block's hs, vs and porch inputs directly.

Parameters:
- LINE_CLKS, 1536: clocks per line (64 us at 24 MHz).
- FPORCH_CLKS, 40: front porch length, from line start.
- HS_CLKS, 113: horizontal sync pulse length.
- BPORCH_CLKS, 137: back porch length; the burst window.
- FIELD_LINES, 312: lines per field; line counter wraps at FIELD_LINES-1.
- SSYNC_CLKS, 48: short (equalising) pulse length.
- LSYNC_CLKS, 720: long (broad) pulse length.
- BLACK, 12: blanking/black level code.
- VEC_LINES, 24: number of vertical sync lines in Vector mode.
- VEC_LSYNC_CLKS, 672: Vector-mode vertical pulse length per line (28 us).

Ports:
- clk, in, 1: 24 MHz clock.
- reset, in, 1: synchronous, active-high.
- ce, in, 1: clock enable; counters and outputs advance only when ce=1.
- luma_i, in, 6: active-video luma, added above BLACK.
- cvbs_o, out, 6: sync-level composite: 0 = sync tip, BLACK = blank, BLACK+luma = picture.
- hsync_o, out, 1: active-high, asserted during the horizontal sync pulse.
- vsync_o, out, 1: active-high, asserted during the vertical sync interval.
- porch_o, out, 1: high during the back porch of non-vsync lines.
- active_o, out, 1: high during the picture region.
- line_o, out, 9: current line, 0..FIELD_LINES-1.
- pixel_o, out, 11: current clock within the line, 0..LINE_CLKS-1.

Behaviour:
- Reset: pixel=0, line=0; cvbs_o=BLACK; hsync_o, vsync_o, porch_o and active_o all 0.
  - Reset wins over ce.
  - Reset mid-line restarts the field at line 0, pixel 0 on the next enabled cycle.
- Counters (only when ce=1):
  - pixel increments and wraps at LINE_CLKS-1 to 0.
  - On that wrap, line increments; line wraps at FIELD_LINES-1 to 0.
  - With ce=0, all state and outputs hold.
- Outputs are registered and decoded from the current (pixel, line), so each output is 1 enabled cycle behind its counter value. line_o and pixel_o show the counters directly, unregistered.
- Normal lines (line >= 6): windows are half-open [a, b).
  - pixel in [0, FP): cvbs_o=BLACK.
  - pixel in [FP, FP+HS): cvbs_o=0, hsync_o=1.
  - pixel in [FP+HS, FP+HS+BP): cvbs_o=BLACK, porch_o=1.
  - Remaining pixels: active_o=1, cvbs_o = min(BLACK+luma_i, 63). The sum is computed 7-bit and saturates to 63.
- Vertical interval (default, PAL-like, lines 0..5): vsync_o=1 for the whole line; porch_o=0; active_o=0. Each line has two half-line slots, at pixel 0 and at LINE_CLKS/2. In each slot, cvbs_o=0 for the pulse length, then BLACK.
  - Lines 0-1: long+long.
  - Line 2: long+short.
  - Lines 3-5: short+short.
  - hsync_o follows each pulse, i.e. is high whenever cvbs_o=0.
- State machine over line region: ST_VSYNC, ST_BLANK, ST_ACTIVE.
  - ST_BLANK covers lines 6..22: normal sync, but active_o=0 and picture region held at BLACK.
  - ST_ACTIVE covers lines 23..FIELD_LINES-1.
  - Region transitions happen only at the line wrap.

Optional Feature:
- Macro: CVBS_SYNCGEN_VECTORSYNC_EN.
- Defined: Vector-06c style vertical interval.
  - Lines 0..VEC_LINES-1 carry one pulse per line: cvbs_o=0, hsync_o=1 for pixel < VEC_LSYNC_CLKS, then BLACK.
  - vsync_o=1 for those lines.
  - Normal hsync width becomes 257 clocks (10.7 us); FPORCH and BPORCH are unchanged.
  - ST_BLANK covers lines VEC_LINES..VEC_LINES+1.
- Undefined: PAL equalising/broad-pulse scheme as above.

Decomposition:
- Package cvbs_pkg holds:
  - Timing constants (24 MHz clock; the derived clock counts).
  - The BLACK level.
  - The region enum {ST_VSYNC, ST_BLANK, ST_ACTIVE}.
  - The saturating add function sat_add6.
- One natural sub-module: cvbs_timing_cnt.
  - ce-gated pixel/line counter pair.
  - Outputs a line_wrap strobe.
  - Reused by future timing masters.

Test Plan:
- Reset/hold: assert reset for 3 cycles mid-line, then release with ce=1 → cvbs_o=12, all flags 0; line_o=0 and pixel_o=0 on the first enabled cycle. Then deassert ce for 10 cycles → all outputs frozen.
- Normal line timing: line 100, luma_i=5 → exact transition sequence below. Hsync count per line is exactly 1.
  - cvbs_o=12 for 40 clocks.
  - Then 0 for 113 clocks.
  - Then 12 for 137 clocks, with porch_o high throughout.
  - Then 17 for 1246 clocks, with active_o high.
- Saturation: luma_i=63 on an active line → cvbs_o=63, never wraps to 11.
- PAL vsync (macro off) → lines 0-5 show the pulse sequence L,L / L,L / L,S / S,S / S,S / S,S, with zero-run lengths 720 or 48 starting at pixels 0 and 768. vsync_o is high for exactly 6×1536 clocks.
- Vector mode (macro on) → lines 0..23 each show a single zero run of 672 clocks at pixel 0; normal lines show an hsync width of 257.
- Loopback: connect cvbs_o to syncdetect for 2 fields → its hsync is high exactly once per line on normal lines (period 1536), and its vsync is asserted once per 312-line field.

Source files
------------

// File: rtl/cvbs_pkg.sv
// ============================================================================
// Module  : cvbs_pkg
// Purpose : Timing constants, levels, region type and helpers for cvbs_syncgen
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cvbs_pkg;

    localparam int c_CLK_HZ          = 24_000_000;
    localparam int c_LINE_CLKS       = 1536;     // 64 us at 24 MHz
    localparam int c_FPORCH_CLKS     = 40;
    localparam int c_HS_CLKS         = 113;
    localparam int c_BPORCH_CLKS     = 137;
    localparam int c_FIELD_LINES     = 312;
    localparam int c_SSYNC_CLKS      = 48;
    localparam int c_LSYNC_CLKS      = 720;
    localparam int c_PAL_VS_LINES    = 6;
    localparam int c_ACTIVE_FIRST    = 23;
    localparam int c_VEC_LINES       = 24;
    localparam int c_VEC_LSYNC_CLKS  = 672;      // 28 us
    localparam int c_VEC_HS_CLKS     = 257;      // 10.7 us

    localparam logic [5:0] c_BLACK   = 6'd12;

    typedef enum logic [1:0] {
        ST_VSYNC  = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } region_t;

    // Level + luma, clamped to full scale rather than wrapping into sync.
    function automatic logic [5:0] sat_add6(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[6] ? 6'h3f : s[5:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cvbs_timing_cnt.sv
// ============================================================================
// Module  : cvbs_timing_cnt
// Purpose : ce-gated pixel/line counter pair with a line-wrap strobe
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cvbs_timing_cnt #(
    parameter int LINE_CLKS   = 1536,
    parameter int FIELD_LINES = 312
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ce,
    output logic [10:0] o_pixel,
    output logic [8:0]  o_line,
    output logic        o_line_wrap
);

    localparam logic [10:0] c_PIX_LAST  = 11'(LINE_CLKS - 1);
    localparam logic [8:0]  c_LINE_LAST = 9'(FIELD_LINES - 1);

    logic [10:0] r_pixel;
    logic [8:0]  r_line;
    logic        w_pix_last;

    assign w_pix_last  = (r_pixel == c_PIX_LAST);
    assign o_line_wrap = i_ce && w_pix_last;
    assign o_pixel     = r_pixel;
    assign o_line      = r_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel <= '0;
            r_line  <= '0;
        end else if (i_ce) begin
            if (w_pix_last) begin
                r_pixel <= '0;
                r_line  <= (r_line == c_LINE_LAST) ? '0 : r_line + 9'd1;
            end else begin
                r_pixel <= r_pixel + 11'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cvbs_syncgen.sv
// ============================================================================
// Module  : cvbs_syncgen
// Purpose : PAL-style line/field timing master with 6-bit sync-level CVBS out.
//           Define CVBS_SYNCGEN_VECTORSYNC_EN for the Vector-06c vertical scheme.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cvbs_syncgen
    import cvbs_pkg::*;
#(
    parameter int LINE_CLKS   = cvbs_pkg::c_LINE_CLKS,
    parameter int FIELD_LINES = cvbs_pkg::c_FIELD_LINES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [5:0]  luma_i,
    output logic [5:0]  cvbs_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        porch_o,
    output logic        active_o,
    output logic [8:0]  line_o,
    output logic [10:0] pixel_o
);

`ifdef CVBS_SYNCGEN_VECTORSYNC_EN
    localparam int          c_HS_W       = c_VEC_HS_CLKS;
    localparam logic [8:0]  c_VS_LAST    = 9'(c_VEC_LINES - 1);
    localparam logic [8:0]  c_BLANK_LAST = 9'(c_VEC_LINES + 1);
    localparam logic [10:0] c_VPULSE     = 11'(c_VEC_LSYNC_CLKS);
`else
    localparam int          c_HS_W       = c_HS_CLKS;
    localparam logic [8:0]  c_VS_LAST    = 9'(c_PAL_VS_LINES - 1);
    localparam logic [8:0]  c_BLANK_LAST = 9'(c_ACTIVE_FIRST - 1);
    localparam logic [10:0] c_HALF       = 11'(LINE_CLKS / 2);
    localparam logic [10:0] c_LSYNC      = 11'(c_LSYNC_CLKS);
    localparam logic [10:0] c_SSYNC      = 11'(c_SSYNC_CLKS);
`endif
    localparam logic [10:0] c_HS_START   = 11'(c_FPORCH_CLKS);
    localparam logic [10:0] c_HS_END     = 11'(c_FPORCH_CLKS + c_HS_W);
    localparam logic [10:0] c_BP_END     = 11'(c_FPORCH_CLKS + c_HS_W + c_BPORCH_CLKS);
    localparam logic [8:0]  c_FIELD_LAST = 9'(FIELD_LINES - 1);

    logic [10:0] w_pixel;
    logic [8:0]  w_line;
    logic        w_line_wrap;

    cvbs_timing_cnt #(
        .LINE_CLKS   (LINE_CLKS),
        .FIELD_LINES (FIELD_LINES)
    ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_ce        (ce),
        .o_pixel     (w_pixel),
        .o_line      (w_line),
        .o_line_wrap (w_line_wrap)
    );

    assign pixel_o = w_pixel;
    assign line_o  = w_line;

    region_t     r_state;
    logic [5:0]  r_cvbs;
    logic        r_hs, r_vs, r_porch, r_active;

    logic [5:0]  w_cvbs;
    logic        w_hs, w_vs, w_porch, w_active, w_vpulse;

`ifdef CVBS_SYNCGEN_VECTORSYNC_EN
    assign w_vpulse = (w_pixel < c_VPULSE);
`else
    // Two half-line slots; broad pulses on lines 0-1 and the first half of line 2.
    logic        w_second;
    logic [10:0] w_slot_pos;
    logic [10:0] w_pulse_len;
    assign w_second    = (w_pixel >= c_HALF);
    assign w_slot_pos  = w_second ? (w_pixel - c_HALF) : w_pixel;
    assign w_pulse_len = ((w_line < 9'd2) || ((w_line == 9'd2) && !w_second)) ? c_LSYNC : c_SSYNC;
    assign w_vpulse    = (w_slot_pos < w_pulse_len);
`endif

    always_comb begin
        w_cvbs   = c_BLACK;
        w_hs     = 1'b0;
        w_vs     = 1'b0;
        w_porch  = 1'b0;
        w_active = 1'b0;
        if (r_state == ST_VSYNC) begin
            w_vs = 1'b1;
            w_hs = w_vpulse;
            if (w_vpulse) w_cvbs = 6'd0;
        end else if (w_pixel < c_HS_START) begin
            w_cvbs = c_BLACK;
        end else if (w_pixel < c_HS_END) begin
            w_hs   = 1'b1;
            w_cvbs = 6'd0;
        end else if (w_pixel < c_BP_END) begin
            w_porch = 1'b1;
        end else if (r_state == ST_ACTIVE) begin
            w_active = 1'b1;
            w_cvbs   = sat_add6(c_BLACK, luma_i);
        end
    end

    // Region FSM and registered outputs; the region only moves at a line wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_VSYNC;
            r_cvbs   <= c_BLACK;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_porch  <= 1'b0;
            r_active <= 1'b0;
        end else if (ce) begin
            r_cvbs   <= w_cvbs;
            r_hs     <= w_hs;
            r_vs     <= w_vs;
            r_porch  <= w_porch;
            r_active <= w_active;
            if (w_line_wrap) begin
                case (r_state)
                    ST_VSYNC:  if (w_line == c_VS_LAST)    r_state <= ST_BLANK;
                    ST_BLANK:  if (w_line == c_BLANK_LAST) r_state <= ST_ACTIVE;
                    ST_ACTIVE: if (w_line == c_FIELD_LAST) r_state <= ST_VSYNC;
                    default:                               r_state <= ST_VSYNC;
                endcase
            end
        end
    end

    assign cvbs_o   = r_cvbs;
    assign hsync_o  = r_hs;
    assign vsync_o  = r_vs;
    assign porch_o  = r_porch;
    assign active_o = r_active;

endmodule

`default_nettype wire
